// File: rtl/nn_input_loader.sv
// Host-PIO driven feature loader: a 16-entry feature buffer filled by toggle-handshaked
// commands, streamed to the NN core over a valid/ready interface with a status word.
module nn_input_loader #(
  parameter int FEAT_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       pio_word,
  output logic [31:0]       status_word,
  output logic              feat_valid,
  input  logic              feat_ready,
  output logic [FEAT_W-1:0] feat_data,
  output logic [3:0]        feat_index,
  output logic              feat_last
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_CLEAR = 3'd2;
  localparam logic [2:0] OP_START = 3'd3;

  logic              tog_q;
  logic [0:0]        state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [3:0]        last_idx_q, last_idx_d;
  logic [FEAT_W-1:0] buf_q [16];
  logic [FEAT_W-1:0] buf_d [16];
  logic [7:0]        done_q, done_d;
  logic              err_busy_q, err_busy_d;
  logic              err_op_q, err_op_d;
  logic [3:0]        laddr_q, laddr_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic [FEAT_W-1:0] data_q, data_d;
  logic [31:0]       status_q;

  logic              cmd_s;
  logic [2:0]        op_s;
  logic [3:0]        addr_s;
  logic [FEAT_W-1:0] wdata_s;
  logic              busy_s;
  logic              hs_s;
  logic [3:0]        idx_inc_s;

  // Command decode and next-state for buffer, FSM, stream outputs and flags.
  always_comb begin
    cmd_s      = pio_word[31] ^ tog_q;
    op_s       = pio_word[30:28];
    addr_s     = pio_word[19:16];
    wdata_s    = pio_word[FEAT_W-1:0];
    busy_s     = (state_q == S_STREAM);
    hs_s       = valid_q & feat_ready;
    idx_inc_s  = idx_q + 4'd1;

    state_d    = state_q;
    idx_d      = idx_q;
    last_idx_d = last_idx_q;
    buf_d      = buf_q;
    done_d     = done_q;
    err_busy_d = err_busy_q;
    err_op_d   = err_op_q;
    laddr_d    = laddr_q;
    valid_d    = valid_q;
    last_d     = last_q;
    data_d     = data_q;

    // Commands are judged against the pre-edge state, so one landing on the
    // final handshake of a frame is still rejected as busy.
    if (cmd_s) begin
      case (op_s)
        OP_NOP: begin
        end
        OP_WRITE: begin
          if (busy_s) begin
            err_busy_d = 1'b1;
          end else begin
            buf_d[addr_s] = wdata_s;
            laddr_d       = addr_s;
          end
        end
        OP_CLEAR: begin
          if (busy_s) begin
            err_busy_d = 1'b1;
          end else begin
            for (int i = 0; i < 16; i++) buf_d[i] = '0;
            err_busy_d = 1'b0;
            err_op_d   = 1'b0;
          end
        end
        OP_START: begin
          if (busy_s) begin
            err_busy_d = 1'b1;
          end else begin
            state_d    = S_STREAM;
            idx_d      = 4'd0;
            last_idx_d = addr_s;
            valid_d    = 1'b1;
            data_d     = buf_q[0];
            last_d     = (addr_s == 4'd0);
          end
        end
        default: err_op_d = 1'b1;
      endcase
    end else begin
      err_op_d = err_op_q;
    end

    if (busy_s && hs_s) begin
      if (last_q) begin
        state_d = S_IDLE;
        idx_d   = 4'd0;
        valid_d = 1'b0;
        last_d  = 1'b0;
        data_d  = '0;
        done_d  = done_q + 8'd1;
      end else begin
        idx_d  = idx_inc_s;
        data_d = buf_q[idx_inc_s];
        last_d = (idx_inc_s == last_idx_q);
      end
    end else begin
      idx_d = idx_d;
    end
  end

  // State, buffer and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tog_q      <= 1'b0;
      state_q    <= S_IDLE;
      idx_q      <= 4'd0;
      last_idx_q <= 4'd0;
      for (int i = 0; i < 16; i++) buf_q[i] <= '0;
      done_q     <= 8'd0;
      err_busy_q <= 1'b0;
      err_op_q   <= 1'b0;
      laddr_q    <= 4'd0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      data_q     <= '0;
      status_q   <= 32'd0;
    end else begin
      tog_q      <= pio_word[31];
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_idx_q <= last_idx_d;
      buf_q      <= buf_d;
      done_q     <= done_d;
      err_busy_q <= err_busy_d;
      err_op_q   <= err_op_d;
      laddr_q    <= laddr_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      data_q     <= data_d;
      status_q   <= {tog_q, busy_s, err_busy_q, err_op_q, done_q, laddr_q, 16'h0000};
    end
  end

  assign status_word = status_q;
  assign feat_valid  = valid_q;
  assign feat_data   = data_q;
  assign feat_index  = idx_q;
  assign feat_last   = last_q;

endmodule

// File: doc/nn_input_loader.md
NN_INPUT_LOADER -- requirements
Module: nn_input_loader

Interface
REQ-001 SHALL have parameter FEAT_W, default 16, feature width in bits; legal range 1..16.
REQ-002 SHALL have port clk  in  1  single clock; every flop is clocked on its rising edge.
REQ-003 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have port pio_word  in  32  command word from the NN-input PIO out_port.
REQ-005 SHALL have port status_word  out  32  status word for the host-readable status PIO in_port.
REQ-006 SHALL have port feat_valid  out  1  feature stream valid.
REQ-007 SHALL have port feat_ready  in  1  feature stream ready from the NN core.
REQ-008 SHALL have port feat_data  out  FEAT_W  feature value.
REQ-009 SHALL have port feat_index  out  4  index of the current feature.
REQ-010 SHALL have port feat_last  out  1  marks the final feature of a frame.

Function
REQ-011 SHALL decode pio_word fields as: [31] toggle, [30:28] opcode, [19:16] addr/count, [FEAT_W-1:0] data; all other bits SHALL be ignored.
REQ-012 SHALL execute exactly one command on each rising edge where pio_word[31] differs from the registered tog_q; tog_q SHALL take pio_word[31] on that same edge.
REQ-013 SHALL support opcodes: 0 NOP; 1 WRITE (buf[addr] <= data); 2 CLEAR (all 16 entries <= 0, both sticky errors <= 0); 3 START (stream addr+1 features, i.e. 1..16).
REQ-014 SHALL treat opcodes 4..7 as no operation and set sticky err_opcode.
REQ-015 SHALL hold a 16 x FEAT_W register buffer, indexed modulo 16.
REQ-016 SHALL implement FSM IDLE -> STREAM on an accepted START; STREAM -> IDLE on the edge where feat_valid && feat_ready && feat_last.
REQ-017 SHALL, on entering STREAM, set feat_index=0, latch last_idx=count field, and assert feat_valid on the next edge (one cycle of latency from command detection).
REQ-018 SHALL drive feat_data=buf[feat_index] and feat_last=(feat_index==last_idx) while feat_valid=1.
REQ-019 SHALL increment feat_index on each valid&&ready edge; feat_data, feat_index and feat_last SHALL stay stable while valid && !ready.
REQ-020 SHALL deassert feat_valid in IDLE, with no bubble between consecutive features when ready is held high.
REQ-021 SHALL, while in STREAM, reject WRITE, CLEAR and START (buffer unchanged) and set sticky err_busy; NOP and illegal opcodes in STREAM SHALL behave as in IDLE.
REQ-022 SHALL evaluate state before the transition when a command coincides with the final handshake edge: START/WRITE/CLEAR on that edge are rejected with err_busy set.
REQ-023 SHALL increment 8-bit done_cnt on each completed frame, wrapping 255 -> 0.
REQ-024 SHALL drive registered status_word as: [31] tog_q, [30] busy (STREAM), [29] err_busy, [28] err_opcode, [27:20] done_cnt, [19:16] last written addr, [15:0] 0; the value SHALL reflect the state one edge after the change.
REQ-025 SHALL let the host detect command consumption when status_word[31] equals its written toggle.

Reset
REQ-026 SHALL on reset_n=0 immediately clear tog_q, FSM (IDLE), feat_index, last_idx, buffer, done_cnt, error flags, last addr, status_word, feat_valid, feat_last and feat_data to 0.
REQ-027 SHALL, if reset occurs mid-frame, abandon the frame without incrementing done_cnt; after release, the first command is the first toggle change relative to 0.

Verification
REQ-028 SHALL verify: WRITE addr 0..3 with data 0x0011,0x0022,0x0033,0x0044, then START count=3 with ready=1 -> four consecutive valid beats 0x11,0x22,0x33,0x44 at indices 0..3, last on index 3, status[27:20]=1.
REQ-029 SHALL verify: START count=1 with ready low for 5 cycles -> feat_data/index held stable at index 0; after ready rises, 2 beats, then IDLE.
REQ-030 SHALL verify: WRITE issued during STREAM -> buffer entry unchanged, status[29]=1; subsequent CLEAR in IDLE -> status[29:28]=0 and buffer reads 0 on the next START.
REQ-031 SHALL verify: opcode 6 toggle -> status[28]=1, state unchanged; pio_word changed with the same toggle bit -> no command executed.
REQ-032 SHALL verify: 256 single-feature frames -> done_cnt wraps to 0; START coinciding with the final handshake -> rejected, err_busy=1.
REQ-033 SHALL verify: reset_n asserted at index 2 of a 16-feature frame -> feat_valid=0 asynchronously, all status fields 0 after release.
